// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU layer sequencer.
package npu_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLR,
    LOAD1,
    CONV1,
    LOAD2,
    CONV2,
    FC,
    DONE,
    ERR
  } seq_state_e;

  localparam int unsigned CONV1_PIX = 182;
  localparam int unsigned CONV2_PIX = 132;

  function automatic logic is_busy(input seq_state_e s);
    return !(s inside {IDLE, DONE, ERR});
  endfunction

endpackage

// File: rtl/npu_watchdog.sv
// Idle-progress watchdog: counts enabled cycles without a kick and flags the last one.
module npu_watchdog #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || kick) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/npu_layer_seq.sv
// Autonomous conv1/conv2/fcn layer sequencer with host buffer-load handshake
// and an idle-progress watchdog.
module npu_layer_seq
  import npu_pkg::*;
#(
  parameter int unsigned CHAN      = 10,
  parameter int unsigned CONV1_PIX = npu_pkg::CONV1_PIX,
  parameter int unsigned CONV2_PIX = npu_pkg::CONV2_PIX,
  parameter int unsigned TIMEOUT   = 4096,
  localparam int unsigned CW       = (CHAN > 1) ? $clog2(CHAN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 load_req,
  output logic                 load_sel,
  input  logic                 load_ack,
  output logic                 conv_trigger,
  output logic                 conv_clear,
  output logic                 conv_layer,
  output logic                 psum_clear,
  input  logic                 pixel_valid,
  output logic                 fcn_start,
  input  logic                 fcn_done,
  input  logic signed [23:0]   fcn_logit,
  output logic [CW-1:0]        chan_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic signed [23:0]   result
);

  localparam logic [7:0]    C1_LAST = 8'(CONV1_PIX - 1);
  localparam logic [7:0]    C2_LAST = 8'(CONV2_PIX - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(CHAN - 1);

  seq_state_e         state_q, state_d;
  logic [7:0]         pix_q, pix_d;
  logic [CW-1:0]      chan_q, chan_d;
  logic signed [23:0] result_q, result_d;
  logic done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic load_req_q, load_req_d, load_sel_q, load_sel_d;
  logic trig_q, trig_d, cclr_q, cclr_d, layer_q, layer_d;
  logic pclr_q, pclr_d, fcn_q, fcn_d;

  logic progress, wd_kick, wd_en, wd_expired;

  assign progress = pixel_valid | load_ack | fcn_done;
  assign wd_kick  = progress | abort | (state_d != state_q);
  assign wd_en    = is_busy(state_q);

  npu_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .kick    (wd_kick),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    chan_d   = chan_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    trig_d   = 1'b0;
    cclr_d   = 1'b0;
    pclr_d   = 1'b0;
    fcn_d    = 1'b0;

    // Any progress event in the expiry cycle also clears the watchdog, so it wins.
    if (abort) begin
      state_d  = IDLE;
      pix_d    = '0;
      chan_d   = '0;
      result_d = '0;
      done_d   = 1'b0;
      err_d    = 1'b0;
    end else if (wd_expired && !progress) begin
      state_d = ERR;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_d  = CLR;
            pclr_d   = 1'b1;
            cclr_d   = 1'b1;
            chan_d   = '0;
            result_d = '0;
            done_d   = 1'b0;
            err_d    = 1'b0;
          end
        end
        CLR: state_d = LOAD1;
        LOAD1: begin
          if (load_ack) begin
            state_d = CONV1;
            trig_d  = 1'b1;
            pix_d   = '0;
          end
        end
        CONV1: begin
          if (pixel_valid) begin
            if (pix_q == C1_LAST) begin
              state_d = LOAD2;
              cclr_d  = 1'b1;
            end else if (pix_q != 8'hFF) begin
              pix_d = pix_q + 8'd1;
            end
          end
        end
        LOAD2: begin
          if (load_ack) begin
            state_d = CONV2;
            trig_d  = 1'b1;
            pix_d   = '0;
          end
        end
        CONV2: begin
          if (pixel_valid) begin
            if (pix_q == C2_LAST) begin
              cclr_d = 1'b1;
              if (chan_q == CH_LAST) begin
                state_d = FC;
                fcn_d   = 1'b1;
              end else begin
                state_d = LOAD1;
                chan_d  = chan_q + 1'b1;
              end
            end else if (pix_q != 8'hFF) begin
              pix_d = pix_q + 8'd1;
            end
          end
        end
        FC: begin
          if (fcn_done) begin
            state_d  = DONE;
            result_d = fcn_logit;
            done_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    load_req_d = (state_d == LOAD1) || (state_d == LOAD2);
    load_sel_d = (state_d == LOAD2);
    layer_d    = (state_d == LOAD2) || (state_d == CONV2);
    busy_d     = is_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pix_q      <= '0;
      chan_q     <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      load_req_q <= 1'b0;
      load_sel_q <= 1'b0;
      trig_q     <= 1'b0;
      cclr_q     <= 1'b0;
      layer_q    <= 1'b0;
      pclr_q     <= 1'b0;
      fcn_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      chan_q     <= chan_d;
      result_q   <= result_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      load_req_q <= load_req_d;
      load_sel_q <= load_sel_d;
      trig_q     <= trig_d;
      cclr_q     <= cclr_d;
      layer_q    <= layer_d;
      pclr_q     <= pclr_d;
      fcn_q      <= fcn_d;
    end
  end

  assign load_req     = load_req_q;
  assign load_sel     = load_sel_q;
  assign conv_trigger = trig_q;
  assign conv_clear   = cclr_q;
  assign conv_layer   = layer_q;
  assign psum_clear   = pclr_q;
  assign fcn_start    = fcn_q;
  assign chan_idx     = chan_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign result       = result_q;

endmodule

// File: tb/tb_npu_layer_seq.sv
// Self-checking bench for npu_layer_seq: host/pixel/fcn model plus pulse scoreboard.
module tb_npu_layer_seq;

  localparam int unsigned CHAN = 2;
  localparam int unsigned C1   = 182;
  localparam int unsigned C2   = 132;
  localparam int unsigned TO_A = 64;
  localparam int unsigned TO_B = 8;

  logic clk = 1'b0;
  logic rst, start, abort, load_ack, pixel_valid, fcn_done;
  logic signed [23:0] fcn_logit;

  logic load_req_a, load_sel_a, conv_trigger_a, conv_clear_a, conv_layer_a, psum_clear_a, fcn_start_a;
  logic [0:0] chan_idx_a;
  logic busy_a, done_a, err_a;
  logic signed [23:0] result_a;

  logic load_req_b, load_sel_b, conv_trigger_b, conv_clear_b, conv_layer_b, psum_clear_b, fcn_start_b;
  logic [0:0] chan_idx_b;
  logic busy_b, done_b, err_b;
  logic signed [23:0] result_b;

  npu_layer_seq #(.CHAN(CHAN), .CONV1_PIX(C1), .CONV2_PIX(C2), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .load_req(load_req_a), .load_sel(load_sel_a), .load_ack(load_ack),
    .conv_trigger(conv_trigger_a), .conv_clear(conv_clear_a), .conv_layer(conv_layer_a),
    .psum_clear(psum_clear_a), .pixel_valid(pixel_valid), .fcn_start(fcn_start_a),
    .fcn_done(fcn_done), .fcn_logit(fcn_logit), .chan_idx(chan_idx_a),
    .busy(busy_a), .done(done_a), .err(err_a), .result(result_a)
  );

  npu_layer_seq #(.CHAN(CHAN), .CONV1_PIX(C1), .CONV2_PIX(C2), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .load_req(load_req_b), .load_sel(load_sel_b), .load_ack(load_ack),
    .conv_trigger(conv_trigger_b), .conv_clear(conv_clear_b), .conv_layer(conv_layer_b),
    .psum_clear(psum_clear_b), .pixel_valid(pixel_valid), .fcn_start(fcn_start_b),
    .fcn_done(fcn_done), .fcn_logit(fcn_logit), .chan_idx(chan_idx_b),
    .busy(busy_b), .done(done_b), .err(err_b), .result(result_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse scoreboard for dut_a
  int n_trig, n_clr, n_psum, n_fcn, n_double;
  int trig_layer[$];
  int trig_chan[$];
  bit prev_trig, prev_clr, prev_psum, prev_fcn;

  task automatic clear_mon();
    n_trig = 0; n_clr = 0; n_psum = 0; n_fcn = 0; n_double = 0;
    trig_layer.delete();
    trig_chan.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (conv_trigger_a) begin
      n_trig++;
      trig_layer.push_back(int'(conv_layer_a));
      trig_chan.push_back(int'(chan_idx_a));
    end
    if (conv_clear_a) n_clr++;
    if (psum_clear_a) n_psum++;
    if (fcn_start_a)  n_fcn++;
    if ((conv_trigger_a && prev_trig) || (conv_clear_a && prev_clr) ||
        (psum_clear_a && prev_psum) || (fcn_start_a && prev_fcn)) n_double++;
    prev_trig = conv_trigger_a;
    prev_clr  = conv_clear_a;
    prev_psum = psum_clear_a;
    prev_fcn  = fcn_start_a;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; start = 1'b0; abort = 1'b0; load_ack = 1'b0;
    pixel_valid = 1'b0; fcn_done = 1'b0; fcn_logit = '0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Host: waits for load_req, acks after dly cycles, expects a trigger next cycle.
  task automatic host_load(input logic exp_sel, input int dly);
    int w = 0;
    while (load_req_a !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    checks++;
    if (load_req_a !== 1'b1 || load_sel_a !== exp_sel || conv_layer_a !== exp_sel) begin
      errors++;
      $display("FAIL load_req: req=%b sel=%b layer=%b, want 1 %b %b", load_req_a, load_sel_a, conv_layer_a, exp_sel, exp_sel);
    end
    repeat (dly) tick();
    load_ack = 1'b1;
    tick();
    load_ack = 1'b0;
    checks++;
    if (conv_trigger_a !== 1'b1 || conv_layer_a !== exp_sel || load_req_a !== 1'b0) begin
      errors++;
      $display("FAIL trigger_after_ack: trig=%b layer=%b req=%b, want 1 %b 0", conv_trigger_a, conv_layer_a, load_req_a, exp_sel);
    end
  endtask

  task automatic feed_pixels(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(maxgap, 0)) tick();
      pixel_valid = 1'b1;
      tick();
      pixel_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; pixel_valid = 1'($urandom); load_ack = 1'($urandom);
    fcn_done = 1'b1; fcn_logit = 24'($urandom);
    tick();
    idle_inputs();
    checks++;
    if ({load_req_a, load_sel_a, conv_trigger_a, conv_clear_a, conv_layer_a, psum_clear_a, fcn_start_a,
         chan_idx_a, busy_a, done_a, err_a, result_a} !== 35'd0) begin
      errors++;
      $display("FAIL reset_a: outputs=%h, want 0", {load_req_a, load_sel_a, conv_trigger_a, conv_clear_a,
               conv_layer_a, psum_clear_a, fcn_start_a, chan_idx_a, busy_a, done_a, err_a, result_a});
    end
    checks++;
    if ({load_req_b, load_sel_b, conv_trigger_b, conv_clear_b, conv_layer_b, psum_clear_b, fcn_start_b,
         chan_idx_b, busy_b, done_b, err_b, result_b} !== 35'd0) begin
      errors++;
      $display("FAIL reset_b: outputs=%h, want 0", {load_req_b, load_sel_b, conv_trigger_b, conv_clear_b,
               conv_layer_b, psum_clear_b, fcn_start_b, chan_idx_b, busy_b, done_b, err_b, result_b});
    end
    tick();
    checks++;
    if (busy_a !== 1'b0 || psum_clear_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b psum=%b, want 0 0", busy_a, psum_clear_a);
    end
  endtask

  task automatic run_full(input int ackdly, input logic signed [23:0] logit);
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (psum_clear_a !== 1'b1 || conv_clear_a !== 1'b1 || busy_a !== 1'b1 || done_a !== 1'b0 ||
        err_a !== 1'b0 || result_a !== 24'sd0 || chan_idx_a !== 1'b0) begin
      errors++;
      $display("FAIL clr_state: psum=%b clr=%b busy=%b done=%b err=%b res=%h ch=%0d, want 1 1 1 0 0 0 0",
               psum_clear_a, conv_clear_a, busy_a, done_a, err_a, result_a, chan_idx_a);
    end
    for (int ch = 0; ch < int'(CHAN); ch++) begin
      host_load(1'b0, ackdly);
      feed_pixels(C1, 2);
      checks++;
      if (conv_clear_a !== 1'b1 || load_req_a !== 1'b1 || load_sel_a !== 1'b1 || conv_layer_a !== 1'b1) begin
        errors++;
        $display("FAIL conv1_end ch%0d: clr=%b req=%b sel=%b layer=%b, want 1 1 1 1",
                 ch, conv_clear_a, load_req_a, load_sel_a, conv_layer_a);
      end
      host_load(1'b1, ackdly);
      feed_pixels(C2, 2);
      checks++;
      if (ch == int'(CHAN) - 1) begin
        if (fcn_start_a !== 1'b1 || conv_clear_a !== 1'b1 || conv_layer_a !== 1'b0 || load_req_a !== 1'b0) begin
          errors++;
          $display("FAIL conv2_last: fcn=%b clr=%b layer=%b req=%b, want 1 1 0 0",
                   fcn_start_a, conv_clear_a, conv_layer_a, load_req_a);
        end
      end else begin
        if (conv_clear_a !== 1'b1 || load_req_a !== 1'b1 || load_sel_a !== 1'b0 || int'(chan_idx_a) != ch + 1) begin
          errors++;
          $display("FAIL conv2_next ch%0d: clr=%b req=%b sel=%b ch=%0d, want 1 1 0 %0d",
                   ch, conv_clear_a, load_req_a, load_sel_a, chan_idx_a, ch + 1);
        end
      end
    end
    repeat (4) tick();
    fcn_logit = logit;
    fcn_done  = 1'b1;
    tick();
    fcn_done  = 1'b0;
    checks++;
    if (result_a !== logit || done_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL result: res=%h done=%b busy=%b, want %h 1 0", result_a, done_a, busy_a, logit);
    end
    checks++;
    if (n_trig != 2 * int'(CHAN) || n_clr != 2 * int'(CHAN) + 1 || n_fcn != 1 || n_psum != 1 || n_double != 0) begin
      errors++;
      $display("FAIL pulse_counts: trig=%0d clr=%0d fcn=%0d psum=%0d double=%0d, want %0d %0d 1 1 0",
               n_trig, n_clr, n_fcn, n_psum, n_double, 2 * CHAN, 2 * CHAN + 1);
    end
    for (int k = 0; k < trig_layer.size(); k++) begin
      checks++;
      if (trig_layer[k] != k % 2 || trig_chan[k] != k / 2) begin
        errors++;
        $display("FAIL trig_seq[%0d]: layer=%0d chan=%0d, want %0d %0d", k, trig_layer[k], trig_chan[k], k % 2, k / 2);
      end
    end
  endtask

  task automatic test_full_run();
    run_full(3, -24'sd5);
    checks++;
    if (result_a !== 24'hFFFFFB) begin
      errors++;
      $display("FAIL logit_m5: res=%h, want FFFFFB", result_a);
    end
  endtask

  task automatic test_back_to_back();
    run_full(int'($urandom_range(5, 1)), 24'($urandom));
  endtask

  task automatic test_watchdog();
    int n = 0;
    do_abort();
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    host_load(1'b0, 3);
    feed_pixels(C1 - 1, 1);
    while (err_a !== 1'b1 && n < int'(TO_A) + 10) begin
      tick();
      n++;
    end
    checks++;
    if (err_a !== 1'b1 || n != int'(TO_A)) begin
      errors++;
      $display("FAIL wd_expiry: err=%b after %0d cycles, want 1 after %0d", err_a, n, TO_A);
    end
    checks++;
    if (busy_a !== 1'b0 || load_req_a !== 1'b0 || conv_layer_a !== 1'b0 || n_fcn != 0) begin
      errors++;
      $display("FAIL err_state: busy=%b req=%b layer=%b fcn=%0d, want 0 0 0 0", busy_a, load_req_a, conv_layer_a, n_fcn);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (psum_clear_a !== 1'b1 || conv_clear_a !== 1'b1 || err_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL err_restart: psum=%b clr=%b err=%b busy=%b, want 1 1 0 1", psum_clear_a, conv_clear_a, err_a, busy_a);
    end
    do_abort();
  endtask

  task automatic test_abort_ack();
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    host_load(1'b0, 3);
    feed_pixels(C1, 1);
    tick(); tick();
    abort = 1'b1; load_ack = 1'b1;
    tick();
    abort = 1'b0; load_ack = 1'b0;
    tick();
    checks++;
    if ({load_req_a, load_sel_a, conv_trigger_a, conv_clear_a, conv_layer_a, psum_clear_a, fcn_start_a,
         chan_idx_a, busy_a, done_a, err_a, result_a} !== 35'd0 || n_trig != 1) begin
      errors++;
      $display("FAIL abort_ack: req=%b trig=%b busy=%b layer=%b trig_count=%0d, want 0 0 0 0 1",
               load_req_a, conv_trigger_a, busy_a, conv_layer_a, n_trig);
    end
  endtask

  task automatic test_ignored();
    do_abort();
    start = 1'b1; tick(); start = 1'b0;
    clear_mon();
    host_load(1'b0, 2);
    feed_pixels(10, 1);
    fcn_done = 1'b1; tick(); fcn_done = 1'b0;
    load_ack = 1'b1; tick(); load_ack = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (busy_a !== 1'b1 || conv_layer_a !== 1'b0 || load_req_a !== 1'b0 || chan_idx_a !== 1'b0 ||
        n_trig != 1 || n_psum != 0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL stray_conv1: busy=%b layer=%b req=%b ch=%0d trig=%0d psum=%0d done=%b, want 1 0 0 0 1 0 0",
               busy_a, conv_layer_a, load_req_a, chan_idx_a, n_trig, n_psum, done_a);
    end
    feed_pixels(C1 - 10, 1);
    checks++;
    if (conv_clear_a !== 1'b1 || load_req_a !== 1'b1 || load_sel_a !== 1'b1) begin
      errors++;
      $display("FAIL conv1_count_kept: clr=%b req=%b sel=%b, want 1 1 1", conv_clear_a, load_req_a, load_sel_a);
    end
    pixel_valid = 1'b1; tick(); pixel_valid = 1'b0;
    host_load(1'b1, 2);
    feed_pixels(60, 1);
    start = 1'b1; tick(); start = 1'b0;
    feed_pixels(C2 - 61, 1);
    checks++;
    if (conv_clear_a !== 1'b0 || chan_idx_a !== 1'b0 || busy_a !== 1'b1 || conv_layer_a !== 1'b1 || n_psum != 0) begin
      errors++;
      $display("FAIL start_in_conv2: clr=%b ch=%0d busy=%b layer=%b psum=%0d, want 0 0 1 1 0",
               conv_clear_a, chan_idx_a, busy_a, conv_layer_a, n_psum);
    end
    feed_pixels(1, 0);
    checks++;
    if (conv_clear_a !== 1'b1 || chan_idx_a !== 1'b1 || load_req_a !== 1'b1 || load_sel_a !== 1'b0) begin
      errors++;
      $display("FAIL conv2_count_exact: clr=%b ch=%0d req=%b sel=%b, want 1 1 1 0",
               conv_clear_a, chan_idx_a, load_req_a, load_sel_a);
    end
    do_abort();
  endtask

  task automatic test_wd_race();
    do_abort();
    start = 1'b1; tick(); start = 1'b0;
    host_load(1'b0, 3);
    feed_pixels(C1 - 1, 0);
    repeat (TO_B - 1) tick();
    pixel_valid = 1'b1; tick(); pixel_valid = 1'b0;
    checks++;
    if (err_b !== 1'b0 || conv_clear_b !== 1'b1 || load_req_b !== 1'b1 || load_sel_b !== 1'b1 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL wd_race: err=%b clr=%b req=%b sel=%b busy=%b, want 0 1 1 1 1",
               err_b, conv_clear_b, load_req_b, load_sel_b, busy_b);
    end
    repeat (TO_B - 1) tick();
    checks++;
    if (err_b !== 1'b0 || load_req_b !== 1'b1) begin
      errors++;
      $display("FAIL wd_load_early: err=%b req=%b, want 0 1", err_b, load_req_b);
    end
    tick();
    checks++;
    if (err_b !== 1'b1 || busy_b !== 1'b0 || load_req_b !== 1'b0) begin
      errors++;
      $display("FAIL wd_load_expire: err=%b busy=%b req=%b, want 1 0 0", err_b, busy_b, load_req_b);
    end
    do_abort();
  endtask

  task automatic test_rst_mid();
    do_abort();
    start = 1'b1; tick(); start = 1'b0;
    host_load(1'b0, 1);
    feed_pixels(C1, 0);
    host_load(1'b1, 1);
    feed_pixels(C2, 0);
    host_load(1'b0, 1);
    feed_pixels(30, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({load_req_a, load_sel_a, conv_trigger_a, conv_clear_a, conv_layer_a, psum_clear_a, fcn_start_a,
         chan_idx_a, busy_a, done_a, err_a, result_a} !== 35'd0) begin
      errors++;
      $display("FAIL rst_mid_a: ch=%0d busy=%b done=%b res=%h, want 0 0 0 0", chan_idx_a, busy_a, done_a, result_a);
    end
    checks++;
    if ({load_req_b, load_sel_b, conv_trigger_b, conv_clear_b, conv_layer_b, psum_clear_b, fcn_start_b,
         chan_idx_b, busy_b, done_b, err_b, result_b} !== 35'd0) begin
      errors++;
      $display("FAIL rst_mid_b: ch=%0d busy=%b err=%b res=%h, want 0 0 0 0", chan_idx_b, busy_b, err_b, result_b);
    end
  endtask

  initial begin
    idle_inputs();
    prev_trig = 1'b0; prev_clr = 1'b0; prev_psum = 1'b0; prev_fcn = 1'b0;
    clear_mon();
    test_reset();
    test_full_run();
    test_back_to_back();
    test_watchdog();
    test_abort_ack();
    test_ignored();
    test_wd_race();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
